// File: rtl/register_readback.sv
// ---------------------------------------------------------------------------
// register_readback
//   Read side of the shared register blob. Starting at an addressed register,
//   fetches one byte at a time and serialises it MSB-first for the I2C slave
//   bit engine, handling the master ACK/NACK after every byte and the
//   PCA9685-style auto-increment of the register pointer.
//
//   Build option: REG_READ_SNAPSHOT_EN
//     defined   - each byte is copied into an 8-bit shift register in LOAD,
//                 so blob writes during a byte cannot corrupt it.
//     undefined - sda_o is re-registered from the live blob every cycle.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   register_blob_i    2048-bit blob; register N = bits N*8 (bit7)..N*8+7 (bit0)
//   start_i            start / repeated-start pulse, samples start_addr_i
//   start_addr_i       first register to read
//   auto_inc_i         MODE1.AI, sampled at each ACK
//   shift_i            bit engine consumed the current bit
//   ack_valid_i, ack_i master acknowledge strobe and level (0 = ACK)
//   stop_i             I2C STOP seen
//   sda_o              bit to drive (1 = released)
//   busy_o             not IDLE
//   byte_done_o        pulse after the 8th bit of a byte is consumed
//   read_addr_o        current register pointer
//
// state    | meaning
// IDLE     | bus released, waiting for start_i
// LOAD     | fetch byte at read_addr_o, present its MSB
// SHIFT    | presenting bit (7 - bit_cnt_q), advance on shift_i
// WAIT_ACK | byte sent, waiting for master ACK/NACK
// ---------------------------------------------------------------------------
module register_readback #(
    parameter logic [7:0] AI_LAST_REG = 8'd69
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [0:2047] register_blob_i,
    input  logic          start_i,
    input  logic [7:0]    start_addr_i,
    input  logic          auto_inc_i,
    input  logic          shift_i,
    input  logic          ack_valid_i,
    input  logic          ack_i,
    input  logic          stop_i,
    output logic          sda_o,
    output logic          busy_o,
    output logic          byte_done_o,
    output logic [7:0]    read_addr_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        SHIFT    = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [2:0] bit_cnt_inc;
    logic [7:0] ptr_next;

    assign bit_cnt_inc = bit_cnt_q + 3'd1;

    // The window wraps at AI_LAST_REG; pointers parked above it still count
    // up to 255 and wrap to 0 from there.
    always_comb begin
        ptr_next = read_addr_o + 8'd1;
        if (read_addr_o == AI_LAST_REG || read_addr_o == 8'hFF) begin
            ptr_next = 8'h00;
        end
    end

`ifdef REG_READ_SNAPSHOT_EN
    logic [7:0] shreg_q;
    logic [7:0] load_byte;

    // Ascending blob range: the part-select MSB is the register's bit 7.
    assign load_byte = register_blob_i[{read_addr_o, 3'd0} +: 8];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            sda_o       <= 1'b1;
            busy_o      <= 1'b0;
            byte_done_o <= 1'b0;
            read_addr_o <= 8'h00;
`ifdef REG_READ_SNAPSHOT_EN
            shreg_q     <= 8'h00;
`endif
        end else begin
            byte_done_o <= 1'b0;
            if (stop_i) begin
                state_q <= IDLE;
                sda_o   <= 1'b1;
                busy_o  <= 1'b0;
            end else if (start_i) begin
                // Repeated start abandons any partial byte silently.
                read_addr_o <= start_addr_i;
                bit_cnt_q   <= 3'd0;
                state_q     <= LOAD;
                sda_o       <= 1'b1;
                busy_o      <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        sda_o  <= 1'b1;
                        busy_o <= 1'b0;
                    end
                    LOAD: begin
                        bit_cnt_q <= 3'd0;
                        state_q   <= SHIFT;
                        busy_o    <= 1'b1;
`ifdef REG_READ_SNAPSHOT_EN
                        shreg_q   <= load_byte;
                        sda_o     <= load_byte[7];
`else
                        sda_o     <= register_blob_i[{read_addr_o, 3'd0}];
`endif
                    end
                    SHIFT: begin
                        if (shift_i) begin
                            if (bit_cnt_q == 3'd7) begin
                                byte_done_o <= 1'b1;
                                state_q     <= WAIT_ACK;
                                sda_o       <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_inc;
`ifdef REG_READ_SNAPSHOT_EN
                                shreg_q   <= {shreg_q[6:0], 1'b0};
                                sda_o     <= shreg_q[6];
`else
                                sda_o     <= register_blob_i[{read_addr_o, bit_cnt_inc}];
`endif
                            end
                        end else begin
`ifndef REG_READ_SNAPSHOT_EN
                            // Live view: follows blob writes to the current bit.
                            sda_o <= register_blob_i[{read_addr_o, bit_cnt_q}];
`endif
                        end
                    end
                    WAIT_ACK: begin
                        sda_o <= 1'b1;
                        if (ack_valid_i) begin
                            if (!ack_i) begin
                                if (auto_inc_i) begin
                                    read_addr_o <= ptr_next;
                                end
                                state_q <= LOAD;
                            end else begin
                                state_q <= IDLE;
                                busy_o  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        sda_o   <= 1'b1;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_register_readback.sv
module tb_register_readback;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [0:2047] blob = '0;
    logic          start_i = 1'b0;
    logic [7:0]    start_addr_i = 8'h00;
    logic          auto_inc_i = 1'b0;
    logic          shift_i = 1'b0;
    logic          ack_valid_i = 1'b0;
    logic          ack_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          sda_o;
    logic          busy_o;
    logic          byte_done_o;
    logic [7:0]    read_addr_o;

    int tests = 0;
    int fails = 0;

    register_readback #(.AI_LAST_REG(8'd69)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .register_blob_i (blob),
        .start_i         (start_i),
        .start_addr_i    (start_addr_i),
        .auto_inc_i      (auto_inc_i),
        .shift_i         (shift_i),
        .ack_valid_i     (ack_valid_i),
        .ack_i           (ack_i),
        .stop_i          (stop_i),
        .sda_o           (sda_o),
        .busy_o          (busy_o),
        .byte_done_o     (byte_done_o),
        .read_addr_o     (read_addr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_reg(input int n, input logic [7:0] v);
        blob[n*8 +: 8] = v;
    endtask

    // start pulse, then the LOAD cycle; MSB is on sda_o afterwards
    task automatic do_start(input logic [7:0] a);
        start_i = 1'b1;
        start_addr_i = a;
        tick();
        start_i = 1'b0;
        tick();
    endtask

    task automatic shifts(input int n);
        for (int i = 0; i < n; i++) begin
            shift_i = 1'b1;
            tick();
            shift_i = 1'b0;
        end
    endtask

    // collects bits from bit index 'first' downwards; ends one cycle after last shift
    task automatic rx_bits(input int first, inout logic [7:0] b);
        for (int i = first; i >= 0; i--) begin
            b[i] = sda_o;
            shift_i = 1'b1;
            tick();
            shift_i = 1'b0;
        end
    endtask

    task automatic ack(input logic a);
        ack_valid_i = 1'b1;
        ack_i = a;
        tick();
        ack_valid_i = 1'b0;
        ack_i = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] b;

        // reset values
        #12;
        check("rst_sda", sda_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_done", byte_done_o, 0);
        check("rst_addr", read_addr_o, 8'h00);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        set_reg(8'h05, 8'hA5);
        set_reg(68, 8'h11);
        set_reg(69, 8'h22);
        set_reg(0, 8'h33);
        set_reg(6, 8'h3C);
        set_reg(255, 8'h80);
        set_reg(70, 8'h44);
        set_reg(71, 8'h55);
        set_reg(8'h10, 8'h5A);

        // single read with NACK
        do_start(8'h05);
        check("single_busy", busy_o, 1);
        b = 8'h00;
        rx_bits(7, b);
        check("single_byte", b, 8'hA5);
        check("single_done", byte_done_o, 1);
        check("single_wait_sda", sda_o, 1);
        tick();
        check("single_done_clr", byte_done_o, 0);
        ack(1'b1);
        check("single_idle", busy_o, 0);
        check("single_addr", read_addr_o, 8'h05);

        // auto-increment across AI_LAST_REG wrap
        auto_inc_i = 1'b1;
        do_start(8'd68);
        rx_bits(7, b);
        check("ai_byte68", b, 8'h11);
        ack(1'b0);
        check("ai_addr69", read_addr_o, 8'd69);
        rx_bits(7, b);
        check("ai_byte69", b, 8'h22);
        ack(1'b0);
        check("ai_addr_wrap", read_addr_o, 8'd0);
        rx_bits(7, b);
        check("ai_byte0", b, 8'h33);
        ack(1'b1);
        check("ai_final_addr", read_addr_o, 8'd0);
        check("ai_idle", busy_o, 0);

        // above the window: plain increment
        do_start(8'd70);
        rx_bits(7, b);
        check("above_byte70", b, 8'h44);
        ack(1'b0);
        check("above_addr71", read_addr_o, 8'd71);
        rx_bits(7, b);
        check("above_byte71", b, 8'h55);
        ack(1'b1);

        // no auto-increment: same register re-read
        auto_inc_i = 1'b0;
        do_start(8'h06);
        rx_bits(7, b);
        check("noai_byte_a", b, 8'h3C);
        ack(1'b0);
        check("noai_addr_a", read_addr_o, 8'h06);
        rx_bits(7, b);
        check("noai_byte_b", b, 8'h3C);
        ack(1'b1);
        check("noai_addr_b", read_addr_o, 8'h06);

        // top wrap 0xFF -> 0x00
        auto_inc_i = 1'b1;
        do_start(8'hFF);
        rx_bits(7, b);
        check("top_byte", b, 8'h80);
        ack(1'b0);
        check("top_addr", read_addr_o, 8'h00);
        rx_bits(7, b);
        check("top_next_byte", b, 8'h33);
        ack(1'b1);

        // stop after 3 shifts
        do_start(8'h05);
        shifts(3);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("stop_busy", busy_o, 0);
        check("stop_sda", sda_o, 1);
        check("stop_done", byte_done_o, 0);
        check("stop_addr", read_addr_o, 8'h05);
        shifts(6);
        check("idle_shift_done", byte_done_o, 0);
        check("idle_shift_busy", busy_o, 0);

        // stop and start together: stop wins
        start_i = 1'b1;
        stop_i = 1'b1;
        start_addr_i = 8'h10;
        tick();
        start_i = 1'b0;
        stop_i = 1'b0;
        check("stopstart_busy", busy_o, 0);
        check("stopstart_addr", read_addr_o, 8'h05);

        // repeated start mid-byte, coincident with shift (start wins)
        do_start(8'h05);
        shifts(3);
        start_i = 1'b1;
        shift_i = 1'b1;
        start_addr_i = 8'h10;
        tick();
        start_i = 1'b0;
        shift_i = 1'b0;
        check("rstart_addr", read_addr_o, 8'h10);
        check("rstart_done", byte_done_o, 0);
        tick();
        rx_bits(7, b);
        check("rstart_byte", b, 8'h5A);
        ack(1'b1);

        // async reset mid-byte
        do_start(8'h05);
        shifts(4);
        #2;
        rst_ni = 1'b0;
        #1;
        check("amid_sda", sda_o, 1);
        check("amid_busy", busy_o, 0);
        check("amid_done", byte_done_o, 0);
        check("amid_addr", read_addr_o, 8'h00);
        tick();
        rst_ni = 1'b1;
        shifts(4);
        check("amid_post_done", byte_done_o, 0);
        check("amid_post_busy", busy_o, 0);

        // blob write mid-byte
        set_reg(8'h05, 8'h00);
        do_start(8'h05);
        b = 8'h00;
        rx_bits(7, b);
        check("snap_pre", b, 8'h00);
        ack(1'b1);
        do_start(8'h05);
        b = 8'hFF;
        b[7] = sda_o;
        shifts(1);
        b[6] = sda_o;
        shifts(1);
        set_reg(8'h05, 8'hFF);
        tick();
        rx_bits(5, b);
`ifdef REG_READ_SNAPSHOT_EN
        check("snap_byte", b, 8'h00);
`else
        check("snap_byte", b, 8'h3F);
`endif
        check("snap_done", byte_done_o, 1);
        ack(1'b1);
        check("snap_idle", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
